// File: rtl/digseg_pkg.sv
// Shared constants for the 8-digit seven-segment controller: register offsets,
// digit count and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package digseg_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [2:0] DIGSEG_DIG_LO = 3'b000;
    localparam logic [2:0] DIGSEG_DIG_HI = 3'b010;
    localparam logic [2:0] DIGSEG_CTRL   = 3'b100;
    localparam logic [2:0] DIGSEG_BLINK  = 3'b110;

    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decode
    import digseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_PATTERNS[i_nibble];

endmodule

// File: rtl/digseg8_ctrl.sv
// Memory-mapped 8-digit multiplexed seven-segment controller on the minisys I/O bus.
// Optional blink support is compiled in with `define DIGSEG_BLINK_EN.
module digseg8_ctrl
    import digseg_pkg::*;
#(
    parameter int SCAN_DIV     = 25000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        digctrl,
    input  logic        iowrite,
    input  logic        ioread,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [DIV_W-1:0]        r_div_cnt;
    logic [2:0]              r_dig_idx;

    logic       w_wr;
    logic       w_tc;
    logic       w_blank;
    logic       w_lit;
    logic [3:0] w_nibble;
    logic [6:0] w_seg;
    logic [15:0] w_blink_rd;

    assign w_wr = digctrl & iowrite;
    assign w_tc = (r_div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clock) begin
        if (rst) begin
            r_digits <= '0;
            r_en     <= '0;
            r_dp     <= '0;
        end else if (w_wr) begin
            case (addr)
                DIGSEG_DIG_LO: r_digits[15:0]  <= wdata;
                DIGSEG_DIG_HI: r_digits[31:16] <= wdata;
                DIGSEG_CTRL: begin
                    r_en <= wdata[7:0];
                    r_dp <= wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_dig_idx <= r_dig_idx + 3'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

`ifdef DIGSEG_BLINK_EN
    localparam int BC_W = $clog2(BLINK_FRAMES) + 1;

    logic [NUM_DIGITS-1:0] r_blink;
    logic [BC_W-1:0]       r_blink_cnt;
    logic                  r_blink_phase;

    // A frame completes when the last digit's slot reaches terminal count.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_blink       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_wr && addr == DIGSEG_BLINK)
                r_blink <= wdata[7:0];
            if (w_tc && r_dig_idx == 3'd7) begin
                if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BC_W'(1);
                end
            end
        end
    end

    assign w_blank    = r_blink_phase & r_blink[r_dig_idx];
    assign w_blink_rd = {8'h00, r_blink};
`else
    assign w_blank    = 1'b0;
    assign w_blink_rd = 16'h0000;
`endif

    // Readback shows register contents before any same-cycle write lands.
    always_comb begin
        rdata = 16'h0000;
        if (digctrl && ioread) begin
            case (addr)
                DIGSEG_DIG_LO: rdata = r_digits[15:0];
                DIGSEG_DIG_HI: rdata = r_digits[31:16];
                DIGSEG_CTRL:   rdata = {r_dp, r_en};
                DIGSEG_BLINK:  rdata = w_blink_rd;
                default:       rdata = 16'h0000;
            endcase
        end
    end

    assign w_nibble = r_digits[{r_dig_idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // First cycle of every slot stays dark to avoid ghosting between digits.
    assign w_lit = (r_div_cnt != '0) && r_en[r_dig_idx] && !w_blank;

    always_ff @(posedge clock) begin
        if (rst) begin
            seg_an  <= 8'hFF;
            seg_out <= 8'hFF;
        end else if (w_lit) begin
            seg_an  <= ~(8'b0000_0001 << r_dig_idx);
            seg_out <= {~r_dp[r_dig_idx], w_seg};
        end else begin
            seg_an  <= 8'hFF;
            seg_out <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_digseg8_ctrl.sv
// Randomized self-checking bench for digseg8_ctrl against a cycle-count based reference model.
module tb_digseg8_ctrl;

    localparam int SD = 4;
    localparam int BF = 2;

    // Standard active-high hex glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        digctrl = 1'b0;
    logic        iowrite = 1'b0;
    logic        ioread = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] rdata;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_dig = '0;
    logic [7:0]  m_en = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_blink = '0;
    int          m_n = 0;

    digseg8_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clock   (clock),
        .rst     (rst),
        .digctrl (digctrl),
        .iowrite (iowrite),
        .ioread  (ioread),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .seg_an  (seg_an),
        .seg_out (seg_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, m_n);
        end
    endtask

    function automatic logic [15:0] mread(input logic [2:0] a);
        case (a)
            3'd0: return m_dig[15:0];
            3'd2: return m_dig[31:16];
            3'd4: return {m_dp, m_en};
`ifdef DIGSEG_BLINK_EN
            3'd6: return {8'h00, m_blink};
`endif
            default: return 16'h0;
        endcase
    endfunction

    task automatic mwrite(input logic [2:0] a, input logic [15:0] d);
        case (a)
            3'd0: m_dig[15:0] = d;
            3'd2: m_dig[31:16] = d;
            3'd4: begin m_en = d[7:0]; m_dp = d[15:8]; end
`ifdef DIGSEG_BLINK_EN
            3'd6: m_blink = d[7:0];
`endif
            default: ;
        endcase
    endtask

    function automatic logic blanked(input int idx);
`ifdef DIGSEG_BLINK_EN
        return (((m_n / (8 * SD)) / BF) % 2 == 1) && m_blink[idx];
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic r, input logic sel, input logic we, input logic re,
                        input logic [2:0] a, input logic [15:0] d);
        logic [7:0] ea, eo;
        logic [3:0] nib;
        int idx;
        logic lit;
        rst = r; digctrl = sel; iowrite = we; ioread = re; addr = a; wdata = d;
        #1;
        chk("rdata", {16'h0, rdata}, {16'h0, (sel && re) ? mread(a) : 16'h0});
        idx = (m_n / SD) % 8;
        lit = (m_n % SD != 0) && m_en[idx] && !blanked(idx);
        ea = 8'hFF;
        eo = 8'hFF;
        if (!r && lit) begin
            nib = m_dig[idx*4 +: 4];
            ea[idx] = 1'b0;
            eo = {~m_dp[idx], ~GLYPH_HI[nib]};
        end
        @(posedge clock);
        if (r) begin
            m_dig = '0; m_en = '0; m_dp = '0; m_blink = '0; m_n = 0;
        end else begin
            if (sel && we) mwrite(a, d);
            m_n++;
        end
        #1;
        chk("seg_an", {24'h0, seg_an}, {24'h0, ea});
        chk("seg_out", {24'h0, seg_out}, {24'h0, eo});
        iowrite = 1'b0; ioread = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        step(1'b0, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b0, 1'b1, 1'b0, 1'b1, a, 16'h0);
    endtask

    initial begin
        int hits;
        logic [2:0] ra;

        // Reset and empty readback
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) rd(3'(i));

        // Single digit
        wr(3'd0, 16'h0003);
        wr(3'd4, 16'h0001);
        idle(32);
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            idle(1);
            if (seg_an == 8'hFE && seg_out == 8'hB0) hits++;
        end
        chk("digit0_lit_cycles", hits, 3);

        // Full scan with wrap and dp on digit 7
        wr(3'd0, 16'h3210);
        wr(3'd2, 16'h7654);
        wr(3'd4, 16'h80FF);
        idle(80);

        // Readback and invalid offset
        wr(3'd4, 16'hA55A);
        rd(3'd4);
        wr(3'd1, 16'hFFFF);
        for (int i = 0; i < 8; i++) rd(3'(i));

        // Read and write together: rdata shows old value
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 16'hBEEF);
        rd(3'd0);

        // Write on terminal count into digit 0
        wr(3'd4, 16'h00FF);
        for (int i = 0; i < 32 && (m_n % (8 * SD)) != (8 * SD - 1); i++) idle(1);
        wr(3'd0, 16'h000C);
        idle(1);
        idle(1);
        chk("simul_an", {24'h0, seg_an}, 32'hFE);
        chk("simul_glyph", {24'h0, seg_out}, 32'hC6);
        idle(12);

        // Blink
        wr(3'd4, 16'h00FF);
        wr(3'd6, 16'h0001);
        rd(3'd6);
        idle(8 * SD * 5);

        // Mid-scan reset
        idle(5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        idle(10);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ra = 3'($urandom_range(0, 7));
            step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), ra, 16'($urandom));
            if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/digseg8_ctrl.md
# digseg8_ctrl

Memory-mapped 8-digit seven-segment display controller on the minisys I/O bus. It is the write-side peripheral counterpart to the switch input path: the CPU stores hex digits, enable, decimal-point and blink masks through `memorio` with `iowrite`. The block time-multiplexes the digits onto shared active-low segment and anode lines, and returns register contents to the `ioread` mux on reads.

## Interface
- `SCAN_DIV`, default 25000: clock cycles per digit slot, minimum 4.
- `BLINK_FRAMES`, default 64: full 8-digit frames per blink half-period. Used only with blink compiled in.
- `clock`  in  1  CPU clock (the `cpuclk` output). Sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `digctrl`  in  1  chip select from `memorio` address decode.
- `iowrite`  in  1  I/O write strobe.
- `ioread`  in  1  I/O read strobe.
- `addr`  in  3  low address bits: byte offset within the block.
- `wdata`  in  16  write data (low half of `write_data`).
- `rdata`  out  16  readback to the `ioread` mux. 0 when not selected.
- `seg_an`  out  8  digit anodes, active-low, bit i = digit i.
- `seg_out`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Register map, decoded on `addr`:
  - 3'b000 DIG_LO: digits 3..0, 4 bits each, digit 0 in [3:0].
  - 3'b010 DIG_HI: digits 7..4.
  - 3'b100 CTRL: [7:0] enable mask (1 = lit), [15:8] dp mask (1 = dp on).
  - 3'b110 BLINK: [7:0] blink mask; [15:8] reads 0.
  - Any other offset: writes ignored, reads 0.
- Write: `digctrl & iowrite` at a rising edge updates the addressed register.
- Read: `rdata` is combinational. It equals the addressed register when `digctrl & ioread`, otherwise 16'h0.
- Read and write asserted together: `rdata` shows the pre-write value. The write still occurs.
- Scan: `div_cnt` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and `dig_idx` increments mod 8 (7 -> 0).
- Guard cycle: in the first cycle of each slot (`div_cnt` == 0), `seg_an` = 8'hFF (anti-ghosting).
- Other cycles of a slot:
  - If digit `dig_idx` is enabled and not blink-suppressed, `seg_an` drives only bit `dig_idx` low.
  - Otherwise `seg_an` = 8'hFF.
- Segment data: `seg_out` = hex-to-7seg pattern of the selected nibble (0-F, full hex glyphs), with dp set from the dp mask. It is 8'hFF whenever `seg_an` is all ones.
- Reset: all registers and counters are 0, `seg_an` = 8'hFF, `seg_out` = 8'hFF, and `rdata` follows the select rule above. A reset in mid-scan restarts at digit 0 with a guard cycle.

## Timing
- `seg_an` and `seg_out` are registered. They reflect the register and counter state of the previous cycle.
- Write-to-display latency: a write at edge N is visible on the outputs at edge N+1 if the current slot's digit is active, or at the next slot otherwise.
- A write coinciding with terminal count: the new value applies to the newly selected digit.
- Frame period = 8 × SCAN_DIV cycles. Each digit is lit for SCAN_DIV-1 cycles per frame.
- `rdata` has zero latency (same cycle as the strobe).

## Configuration
- `DIGSEG_BLINK_EN` defined:
  - `blink_cnt` counts completed frames. After BLINK_FRAMES frames it wraps and toggles `blink_phase`; reset value is 0 (= visible).
  - While `blink_phase` = 1, digits whose blink bit is set are blanked.
  - BLINK is readable and writable.
- `DIGSEG_BLINK_EN` not defined:
  - No blink counter.
  - BLINK writes are ignored and it reads 0.
  - Display depends only on the enable mask.

## Structure
- Package `digseg_pkg`:
  - Register offset constants (`DIGSEG_DIG_LO`, `DIGSEG_DIG_HI`, `DIGSEG_CTRL`, `DIGSEG_BLINK`).
  - `NUM_DIGITS` = 8.
  - The 16-entry active-low segment pattern constant table.
- Sub-module `seg_hex_decode`: combinational nibble -> 7-bit pattern, instantiated once on the muxed nibble.
- The rest (bus regs, scan counters, output regs) lives in `digseg8_ctrl`.

## Test plan
Benches use SCAN_DIV=4 and BLINK_FRAMES=2.
- Reset check: hold `rst` 3 cycles -> `seg_an`=8'hFF, `seg_out`=8'hFF. With `digctrl`/`ioread` at every offset -> `rdata`=0.
- Single digit: write DIG_LO=16'h0003, CTRL=16'h0001.
  - In digit-0 slots, `seg_an`=8'hFE and `seg_out`=8'hB0 for 3 of every 32 cycles.
  - In the guard cycle, `seg_an`=8'hFF.
- Full scan with wrap-around: DIG_LO=16'h3210, DIG_HI=16'h7654, CTRL=16'h80FF.
  - Anodes step FE, FD, … 7F, then back to FE.
  - dp is low only on digit 7.
- Readback and invalid offset:
  - Write CTRL=16'hA55A, read -> 16'hA55A.
  - Write to offset 3'b001, then read every register -> unchanged. Reading 3'b001 -> 0.
- Simultaneous: write DIG_LO on the terminal-count edge into digit 0 -> the first lit cycle of the digit-0 slot shows the new glyph.
- Blink (`DIGSEG_BLINK_EN`): CTRL=16'h00FF, BLINK=16'h0001.
  - Digit 0 is dark for 2 frames, lit for 2 frames, and so on; other digits are always lit.
  - Without the macro, BLINK reads 0 and digit 0 is always lit.
